led_dimmer: RTL and testbench
=============================

LED_DIMMER -- requirements
Module: led_dimmer

Interface
REQ-001 Parameters SHALL be: WIDTH, 18, number of LED lines; PRESCALE, 196, clk cycles per PWM step (minimum 1).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 led_in  input  WIDTH  LED pattern from upstream PIO out_port, synchronous to clk.
REQ-005 address  input  2  Avalon-MM slave word address.
REQ-006 chipselect  input  1  slave select.
REQ-007 write_n  input  1  active-low write strobe.
REQ-008 writedata  input  32  write data.
REQ-009 readdata  output  32  read data, zero-wait-state.
REQ-010 led_out  output  WIDTH  dimmed/blinked LED drive to pins.

Function
REQ-011 Register map SHALL be: 0 CTRL (bit0 enable, bit1 blink_en); 1 DUTY ([7:0]); 2 BLINK ([15:0] half-period in PWM frames); 3 STATUS (read-only: bit0 blink phase, [15:8] pwm_cnt).
REQ-012 Write SHALL occur when chipselect=1 and write_n=0; bits beyond field width ignored; writes to address 3 ignored.
REQ-013 readdata SHALL be combinational from address, unused bits zero, DUTY reads the written (pending) value.
REQ-014 Prescaler SHALL count 0..PRESCALE-1 while enable=1 and assert a one-cycle tick on the terminal count.
REQ-015 8-bit pwm_cnt SHALL increment on each tick, wrapping 255->0; the wrap cycle is frame_end.
REQ-016 Active duty SHALL load from DUTY only at frame_end (or reset); mid-frame DUTY writes SHALL not alter the current frame.
REQ-017 pwm_on SHALL be (pwm_cnt < active duty), except active duty 255 forces pwm_on=1 and duty 0 gives pwm_on=0.
REQ-018 Blink counter SHALL count frame_end events; on reaching max(BLINK,1)-1 with another frame_end it SHALL toggle phase and clear.
REQ-019 BLINK writes SHALL clear the blink counter in the same cycle; simultaneous frame_end is then not counted.
REQ-020 led_out SHALL register (led_in AND pwm_on AND (phase OR NOT blink_en)) replicated per bit, when enable=1: one clk latency from led_in.
REQ-021 enable=0 SHALL force led_out=0 next cycle and hold prescaler, pwm_cnt, blink counter at 0 and phase at 1.
REQ-022 Clearing blink_en SHALL not reset phase; LEDs follow pwm_on immediately.

Reset
REQ-023 Reset SHALL set: CTRL=0x1, DUTY=0xFF, active duty=0xFF, BLINK=0x0010, prescaler=0, pwm_cnt=0, blink counter=0, phase=1, led_out=0.
REQ-024 Reset asserted mid-frame SHALL take effect immediately (asynchronous), and first led_out update SHALL follow the first clk edge after deassertion.

Structure
REQ-025 Package led_dimmer_pkg SHALL hold register address constants, field bit positions, and reset values for CTRL, DUTY, BLINK.
REQ-026 Prescaler plus pwm_cnt plus duty shadow SHALL be a sub-module led_dimmer_pwm (ports: clk, reset_n, enable, duty, pwm_on, frame_end, pwm_cnt).
REQ-027 Register file, blink logic, output register SHALL reside in led_dimmer top.

Verification (PRESCALE=2 in bench)
REQ-028 Post-reset, led_in=0x3FFFF -> led_out=0x3FFFF from cycle 2 continuously (duty 255, blink off).
REQ-029 Write DUTY=0x40, led_in=0x00001 -> after next frame_end led_out[0] high 128 cycles, low 384 cycles per 512-cycle frame.
REQ-030 Write DUTY=0x80 at pwm_cnt=10 -> current frame keeps duty 0xFF; 0x80 active from next frame start.
REQ-031 CTRL=0x3, BLINK=2, DUTY=0xFF -> phase toggles every 2 frames (1024 cycles); led_out zero during phase 0; STATUS bit0 tracks phase.
REQ-032 CTRL=0x0 mid-frame -> led_out=0 next cycle, STATUS reads 0x0001; re-enable restarts pwm_cnt from 0.
REQ-033 Assert reset_n low mid-blink -> led_out=0 asynchronously; readback CTRL=0x1, DUTY=0xFF, BLINK=0x0010.

Source files
------------

// File: rtl/led_dimmer_pkg.sv
// Shared constants for the LED dimmer: register map, field positions and reset values.
package led_dimmer_pkg;

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrDuty   = 2'd1;
    localparam logic [1:0] AddrBlink  = 2'd2;
    localparam logic [1:0] AddrStatus = 2'd3;

    localparam int unsigned CtrlW  = 2;
    localparam int unsigned DutyW  = 8;
    localparam int unsigned BlinkW = 16;

    localparam int unsigned CtrlEnableBit  = 0;
    localparam int unsigned CtrlBlinkBit   = 1;
    localparam int unsigned StatusPhaseBit = 0;
    localparam int unsigned StatusCntLsb   = 8;

    localparam logic [CtrlW-1:0]  CtrlRst  = 2'b01;
    localparam logic [DutyW-1:0]  DutyRst  = 8'hFF;
    localparam logic [BlinkW-1:0] BlinkRst = 16'h0010;

    // A half-period of 0 behaves like 1: toggle on every frame.
    function automatic logic [BlinkW-1:0] blink_last(input logic [BlinkW-1:0] half);
        return (half == '0) ? '0 : half - 1'b1;
    endfunction

endpackage

// File: rtl/led_dimmer_pwm.sv
// PWM core: prescaler, 8-bit frame counter and a duty shadow that only reloads at frame end.
module led_dimmer_pwm
    import led_dimmer_pkg::*;
#(
    parameter int unsigned PRESCALE = 196
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DutyW-1:0] duty,
    output logic             pwm_on,
    output logic             frame_end,
    output logic [7:0]       pwm_cnt
);

    localparam int unsigned     PreW    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

    logic [PreW-1:0]  r_pre;
    logic [7:0]       r_cnt;
    logic [DutyW-1:0] r_active;
    logic             w_tick;

    assign w_tick    = enable && (r_pre == PreLast);
    assign frame_end = w_tick && (r_cnt == 8'hFF);
    assign pwm_cnt   = r_cnt;

    // Full-scale duty must never dip, even on the pwm_cnt == 255 step.
    assign pwm_on = (r_active == 8'hFF) || (r_cnt < r_active);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pre    <= '0;
            r_cnt    <= '0;
            r_active <= DutyRst;
        end else if (!enable) begin
            r_pre <= '0;
            r_cnt <= '0;
        end else begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (w_tick) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (frame_end) begin
                r_active <= duty;
            end
        end
    end

endmodule

// File: rtl/led_dimmer.sv
// Avalon-MM LED dimmer: register file, blink phase generator and registered LED outputs.
module led_dimmer
    import led_dimmer_pkg::*;
#(
    parameter int unsigned WIDTH    = 18,
    parameter int unsigned PRESCALE = 196
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] led_in,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] led_out
);

    logic [CtrlW-1:0]  r_ctrl;
    logic [DutyW-1:0]  r_duty;
    logic [BlinkW-1:0] r_blink;
    logic [BlinkW-1:0] r_blink_cnt;
    logic              r_phase;
    logic [WIDTH-1:0]  r_led_out;

    logic       w_we;
    logic       w_blink_wr;
    logic       w_enable;
    logic       w_blink_en;
    logic       w_pwm_on;
    logic       w_frame_end;
    logic [7:0] w_pwm_cnt;
    logic       w_led_gate;
    logic       w_unused;

    assign w_we       = chipselect && !write_n;
    assign w_blink_wr = w_we && (address == AddrBlink);
    assign w_enable   = r_ctrl[CtrlEnableBit];
    assign w_blink_en = r_ctrl[CtrlBlinkBit];
    assign w_led_gate = w_pwm_on && (r_phase || !w_blink_en);
    assign led_out    = r_led_out;
    assign w_unused   = ^writedata[31:BlinkW];

    led_dimmer_pwm #(
        .PRESCALE(PRESCALE)
    ) u_pwm (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (w_enable),
        .duty     (r_duty),
        .pwm_on   (w_pwm_on),
        .frame_end(w_frame_end),
        .pwm_cnt  (w_pwm_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctrl  <= CtrlRst;
            r_duty  <= DutyRst;
            r_blink <= BlinkRst;
        end else if (w_we) begin
            unique case (address)
                AddrCtrl:  r_ctrl  <= writedata[CtrlW-1:0];
                AddrDuty:  r_duty  <= writedata[DutyW-1:0];
                AddrBlink: r_blink <= writedata[BlinkW-1:0];
                default:   ;
            endcase
        end
    end

    // A BLINK write restarts the half-period count, swallowing a coincident frame_end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (!w_enable) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_blink_wr) begin
            r_blink_cnt <= '0;
        end else if (w_frame_end) begin
            if (r_blink_cnt >= blink_last(r_blink)) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_led_out <= '0;
        end else if (!w_enable) begin
            r_led_out <= '0;
        end else begin
            r_led_out <= led_in & {WIDTH{w_led_gate}};
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            AddrCtrl:  readdata[CtrlW-1:0]  = r_ctrl;
            AddrDuty:  readdata[DutyW-1:0]  = r_duty;
            AddrBlink: readdata[BlinkW-1:0] = r_blink;
            AddrStatus: begin
                readdata[StatusPhaseBit]     = r_phase;
                readdata[StatusCntLsb +: 8]  = w_pwm_cnt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_led_dimmer.sv
// Directed bench for led_dimmer with PRESCALE=2 (512-cycle PWM frames).
module tb_led_dimmer;

    localparam int unsigned WIDTH    = 18;
    localparam int unsigned PRESCALE = 2;

    logic             clk;
    logic             reset_n;
    logic [WIDTH-1:0] led_in;
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [31:0]      writedata;
    logic [31:0]      readdata;
    logic [WIDTH-1:0] led_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        cs;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        logic [7:0] duty;
        int         hi;
    } duty_vec_t;

    led_dimmer #(
        .WIDTH   (WIDTH),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .led_in    (led_in),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .led_out   (led_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step(2);
        reset_n = 1'b1;
    endtask

    task automatic count_high(input int n, output int hi);
        hi = 0;
        repeat (n) begin
            step(1);
            if (led_out[0]) hi++;
        end
    endtask

    task automatic wait_cnt(input logic [7:0] target, output bit ok);
        logic [31:0] d;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            step(1);
            reg_read(2'd3, d);
            if (d[15:8] == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_phase(input logic val, output bit ok);
        logic [31:0] d;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            reg_read(2'd3, d);
            if (d[0] == val) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    initial begin
        reg_vec_t    vecs[14];
        duty_vec_t   dvecs[5];
        logic [31:0] d;
        int          hi;
        int          errs;
        int          lows;
        bit          ok;
        int          tog[3];
        int          ntog;
        logic        prev_phase;
        int          bad_off;
        int          bad_on;

        vecs[0]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 32'h0000_0001};
        vecs[1]  = '{1'b0, 1'b0, 2'd1, 32'h0000_0000, 32'h0000_00FF};
        vecs[2]  = '{1'b0, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0010};
        vecs[3]  = '{1'b1, 1'b1, 2'd1, 32'hABCD_1234, 32'h0000_0034};
        vecs[4]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF_0007, 32'h0000_0007};
        vecs[5]  = '{1'b0, 1'b1, 2'd1, 32'h0000_0055, 32'h0000_0034};
        vecs[6]  = '{1'b1, 1'b1, 2'd0, 32'hFFFF_FFFC, 32'h0000_0000};
        vecs[7]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0000, 32'h0000_0001};
        vecs[8]  = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000};
        vecs[10] = '{1'b0, 1'b0, 2'd1, 32'h0000_0000, 32'h0000_0034};
        vecs[11] = '{1'b0, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0007};
        vecs[12] = '{1'b1, 1'b1, 2'd0, 32'h0000_0002, 32'h0000_0002};
        vecs[13] = '{1'b0, 1'b0, 2'd3, 32'h0000_0000, 32'h0000_0001};

        dvecs[0] = '{8'h40, 128};
        dvecs[1] = '{8'h00, 0};
        dvecs[2] = '{8'h80, 256};
        dvecs[3] = '{8'hFE, 508};
        dvecs[4] = '{8'hFF, 512};

        reset_n    = 1'b1;
        led_in     = '0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        step(1);

        // Reset state and full-on output after reset.
        led_in  = 18'h3FFFF;
        reset_n = 1'b0;
        step(2);
        check("reset_led_out", 32'(led_out), 32'h0);
        reset_n = 1'b1;
        #1;
        check("pre_edge_led_out", 32'(led_out), 32'h0);
        step(1);
        check("first_edge_led_out", 32'(led_out), 32'h3FFFF);
        errs = 0;
        repeat (600) begin
            step(1);
            if (led_out !== 18'h3FFFF) errs++;
        end
        check("full_on_frame_errs", 32'(errs), 32'h0);

        // Register map table.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                address    = vecs[i].addr;
                writedata  = vecs[i].wdata;
                chipselect = vecs[i].cs;
                write_n    = 1'b0;
                step(1);
                chipselect = 1'b0;
                write_n    = 1'b1;
            end
            step(1);
            reg_read(vecs[i].addr, d);
            check($sformatf("reg_vec%0d", i), d, vecs[i].exp);
        end

        // Duty cycle table: high cycles per 512-cycle frame on led_out[0].
        do_reset();
        led_in = 18'h00001;
        errs   = 0;
        for (int i = 0; i < 5; i++) begin
            bus_write(2'd1, 32'(dvecs[i].duty));
            step(600);
            hi = 0;
            repeat (512) begin
                step(1);
                if (led_out[0]) hi++;
                if (led_out[WIDTH-1:1] != '0) errs++;
            end
            check($sformatf("duty_%02h_high", dvecs[i].duty), 32'(hi), 32'(dvecs[i].hi));
        end
        check("duty_other_bits", 32'(errs), 32'h0);

        // Mid-frame DUTY write must not disturb the running frame.
        do_reset();
        led_in = 18'h00001;
        wait_cnt(8'd10, ok);
        check("wait_cnt10", 32'(ok), 32'h1);
        bus_write(2'd1, 32'h80);
        lows = 0;
        repeat (400) begin
            step(1);
            if (!led_out[0]) lows++;
        end
        check("midframe_duty_lows", 32'(lows), 32'h0);
        step(600);
        count_high(512, hi);
        check("next_frame_duty80", 32'(hi), 32'd256);

        // Blink: half-period of 2 frames.
        do_reset();
        led_in = 18'h2AAAA;
        bus_write(2'd2, 32'h2);
        bus_write(2'd0, 32'h3);
        reg_read(2'd3, d);
        check("blink_start_phase", 32'(d[0]), 32'h1);
        prev_phase = d[0];
        ntog    = 0;
        bad_off = 0;
        bad_on  = 0;
        for (int c = 0; c < 3500; c++) begin
            step(1);
            reg_read(2'd3, d);
            if (prev_phase == 1'b0 && led_out != '0) bad_off++;
            if (prev_phase == 1'b1 && led_out != led_in) bad_on++;
            if (d[0] != prev_phase && ntog < 3) begin
                tog[ntog] = c;
                ntog++;
            end
            prev_phase = d[0];
        end
        check("blink_toggles", 32'(ntog), 32'd3);
        if (ntog == 3) begin
            check("blink_interval0", 32'(tog[1] - tog[0]), 32'd1024);
            check("blink_interval1", 32'(tog[2] - tog[1]), 32'd1024);
        end
        check("blink_off_leds", 32'(bad_off), 32'h0);
        check("blink_on_leds", 32'(bad_on), 32'h0);

        // Clearing blink_en in phase 0 keeps phase but frees the LEDs.
        wait_phase(1'b0, ok);
        check("wait_phase0", 32'(ok), 32'h1);
        bus_write(2'd0, 32'h1);
        step(1);
        check("blink_clear_leds", 32'(led_out), 32'h2AAAA);
        reg_read(2'd3, d);
        check("blink_clear_phase", 32'(d[0]), 32'h0);

        // Disable mid-frame, then re-enable.
        wait_cnt(8'd100, ok);
        check("wait_cnt100", 32'(ok), 32'h1);
        bus_write(2'd0, 32'h0);
        step(1);
        check("disable_leds", 32'(led_out), 32'h0);
        reg_read(2'd3, d);
        check("disable_status", d, 32'h0000_0001);
        bus_write(2'd0, 32'h1);
        step(1);
        reg_read(2'd3, d);
        check("reenable_cnt0", 32'(d[15:8]), 32'h0);
        step(1);
        reg_read(2'd3, d);
        check("reenable_cnt1", 32'(d[15:8]), 32'h1);
        check("reenable_leds", 32'(led_out), 32'h2AAAA);

        // Asynchronous reset in the middle of blinking.
        do_reset();
        led_in = 18'h15555;
        bus_write(2'd2, 32'h2);
        bus_write(2'd1, 32'h33);
        bus_write(2'd0, 32'h3);
        step(50);
        check("preasync_leds", 32'(led_out), 32'h15555);
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_leds", 32'(led_out), 32'h0);
        reg_read(2'd0, d);
        check("async_ctrl", d, 32'h1);
        reg_read(2'd1, d);
        check("async_duty", d, 32'hFF);
        reg_read(2'd2, d);
        check("async_blink", d, 32'h10);
        reg_read(2'd3, d);
        check("async_status", d, 32'h1);
        step(2);
        reset_n = 1'b1;
        step(1);
        check("post_reset_leds", 32'(led_out), 32'h15555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
